// File: rtl/sprite_pkg.sv
// Shared definitions for the per-scanline sprite engine.
// Holds the attribute word field positions, the sprite and line geometry,
// the transparent colour key and the scanner state encoding.
package sprite_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int LINE_W   = 640;

  localparam logic [15:0] TRANSPARENT = 16'h0000;

  // Attribute word: {en, flip, rsvd[1:0], y[9:0], x[9:0], frame_id[7:0]}
  localparam int ATTR_EN_BIT    = 31;
  localparam int ATTR_FLIP_BIT  = 30;
  localparam int ATTR_Y_MSB     = 27;
  localparam int ATTR_Y_LSB     = 18;
  localparam int ATTR_X_MSB     = 17;
  localparam int ATTR_X_LSB     = 8;
  localparam int ATTR_FRAME_MSB = 7;
  localparam int ATTR_FRAME_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DRAW = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/sprite_row_fetch.sv
// Draws one 16-pixel sprite row into the line buffer.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle pulse, loads col_base/flip/frame_id/row_off
//   col_base          leftmost line-buffer column of the sprite
//   flip              horizontal mirror
//   frame_id, row_off select the ROM row
//   rom_addr / rom_q  sprite ROM, one cycle read latency
//   pixel_col, pixel_data, wren   line-buffer write port
//   done              one-cycle pulse, 18 cycles after start
module sprite_row_fetch
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  col_base,
  input  logic        flip,
  input  logic [7:0]  frame_id,
  input  logic [3:0]  row_off,
  input  logic [15:0] rom_q,
  output logic        done,
  output logic [15:0] rom_addr,
  output logic [9:0]  pixel_col,
  output logic [15:0] pixel_data,
  output logic        wren
);

  logic       busy_q, busy_d;
  logic [3:0] x_q, x_d;
  logic [9:0] col_q, col_d;
  logic       flip_q, flip_d;
  logic [7:0] frame_q, frame_d;
  logic [3:0] row_q, row_d;
  logic       pix_v_q;
  logic [3:0] pix_x_q;
  logic       done_q;
  logic [10:0] col_sum;

  always_comb begin
    busy_d  = busy_q;
    x_d     = x_q;
    col_d   = col_q;
    flip_d  = flip_q;
    frame_d = frame_q;
    row_d   = row_q;
    if (start) begin
      busy_d  = 1'b1;
      x_d     = 4'd0;
      col_d   = col_base;
      flip_d  = flip;
      frame_d = frame_id;
      row_d   = row_off;
    end else if (busy_q) begin
      x_d = x_q + 4'd1;
      if (x_q == 4'(SPRITE_W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      x_q     <= '0;
      col_q   <= '0;
      flip_q  <= 1'b0;
      frame_q <= '0;
      row_q   <= '0;
      pix_v_q <= 1'b0;
      pix_x_q <= '0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      x_q     <= x_d;
      col_q   <= col_d;
      flip_q  <= flip_d;
      frame_q <= frame_d;
      row_q   <= row_d;
      // Pixel stage trails the address stage by the ROM latency.
      pix_v_q <= busy_q;
      pix_x_q <= x_q;
      done_q  <= pix_v_q && (pix_x_q == 4'(SPRITE_W - 1));
    end
  end

  // 15 - x on a 4-bit index is simply its complement.
  assign rom_addr = busy_q ? {frame_q, row_q, (flip_q ? ~x_q : x_q)} : '0;

  // Unwrapped sum so a sprite hanging off the right edge is clipped
  // rather than wrapping round to the left.
  assign col_sum    = {1'b0, col_q} + {7'd0, pix_x_q};
  assign pixel_col  = pix_v_q ? col_sum[9:0] : '0;
  assign pixel_data = pix_v_q ? rom_q : '0;
  assign wren       = pix_v_q && (rom_q != TRANSPARENT) && (col_sum < 11'(LINE_W));
  assign done       = done_q;

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: scans the attribute RAM for sprites covering
// the requested line and draws up to MAX_SLOT of them into the line buffer.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   start_row, next_vcount  begin building line next_vcount
//   ra / rd_data            attribute RAM, one cycle read latency
//   rom_addr / rom_q        sprite image ROM, one cycle read latency
//   pixel_col, pixel_data, wren   line-buffer write port
//   fe_done                 one-cycle pulse when the line is finished
//
// state   | meaning
// IDLE    | waiting for start_row
// RD      | ra = current attribute index
// WT      | attribute RAM latency
// CHK     | hit test on rd_data, launch drawer on hit
// DRAW    | waiting for drawer done
// DONE    | fe_done pulse
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITE = 32,
  parameter int MAX_SLOT   = 8,
  localparam int IW = $clog2(NUM_SPRITE),
  localparam int SW = $clog2(MAX_SLOT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_row,
  input  logic [9:0]    next_vcount,
  output logic [IW-1:0] ra,
  input  logic [31:0]   rd_data,
  output logic [15:0]   rom_addr,
  input  logic [15:0]   rom_q,
  output logic [9:0]    pixel_col,
  output logic [15:0]   pixel_data,
  output logic          wren,
  output logic          fe_done
);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] slot_q, slot_d, slot_n;
  logic [9:0]    vcount_q, vcount_d;
  logic [9:0]    dy;
  logic          hit, draw_start, draw_done, last;
  logic          attr_unused;

  // Modulo-1024 distance handles sprites straddling line 0.
  assign dy         = vcount_q - rd_data[ATTR_Y_MSB:ATTR_Y_LSB];
  assign hit        = rd_data[ATTR_EN_BIT] && (dy < 10'(SPRITE_H));
  assign draw_start = (state_q == ST_CHK) && hit;
  assign attr_unused = ^rd_data[29:28];

  // Slot count as it will be after the current sprite, for the end test.
  assign slot_n = (state_q == ST_DRAW) ? slot_q + 1'b1 : slot_q;
  assign last   = (idx_q == IW'(NUM_SPRITE - 1)) || (slot_n == SW'(MAX_SLOT));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    vcount_d = vcount_q;
    case (state_q)
      ST_IDLE: if (start_row) begin
        vcount_d = next_vcount;
        idx_d    = '0;
        slot_d   = '0;
        state_d  = ST_RD;
      end
      ST_RD: state_d = ST_WT;
      ST_WT: state_d = ST_CHK;
      ST_CHK: begin
        if (hit)       state_d = ST_DRAW;
        else if (last) state_d = ST_DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_DRAW: if (draw_done) begin
        slot_d = slot_n;
        if (last) state_d = ST_DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      slot_q   <= '0;
      vcount_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      vcount_q <= vcount_d;
    end
  end

  assign ra      = idx_q;
  assign fe_done = (state_q == ST_DONE);

  sprite_row_fetch u_fetch (
    .clk        (clk),
    .reset      (reset),
    .start      (draw_start),
    .col_base   (rd_data[ATTR_X_MSB:ATTR_X_LSB]),
    .flip       (rd_data[ATTR_FLIP_BIT]),
    .frame_id   (rd_data[ATTR_FRAME_MSB:ATTR_FRAME_LSB]),
    .row_off    (dy[3:0]),
    .rom_q      (rom_q),
    .done       (draw_done),
    .rom_addr   (rom_addr),
    .pixel_col  (pixel_col),
    .pixel_data (pixel_data),
    .wren       (wren)
  );

endmodule

// File: tb/tb_sprite_line_engine.sv
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_row;
  logic [9:0]  next_vcount;
  logic [4:0]  ra;
  logic [31:0] rd_data = '0;
  logic [15:0] rom_addr;
  logic [15:0] rom_q = '0;
  logic [9:0]  pixel_col;
  logic [15:0] pixel_data;
  logic        wren;
  logic        fe_done;

  always #5 clk = ~clk;

  sprite_line_engine #(.NUM_SPRITE(32), .MAX_SLOT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_row   (start_row),
    .next_vcount (next_vcount),
    .ra          (ra),
    .rd_data     (rd_data),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pixel_col   (pixel_col),
    .pixel_data  (pixel_data),
    .wren        (wren),
    .fe_done     (fe_done)
  );

  logic [31:0] ram [32];
  logic [15:0] rom [65536];

  always @(posedge clk) begin
    rd_data <= ram[ra];
    rom_q   <= rom[rom_addr];
  end

  typedef struct packed {
    logic [9:0]  col;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  e_w;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic done_seen;
  int   wr_cnt, done_cnt;
  int   wcnt [1024];
  logic [15:0] cap [1024];

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Expected write stream: walk entries in order, keep at most 8 hits,
  // emit every opaque on-screen pixel of each hit.
  task automatic build_model(input logic [9:0] v);
    int slots;
    int col;
    logic [31:0] w;
    logic [9:0]  d;
    logic [15:0] a, data;
    exp_q.delete();
    slots = 0;
    for (int i = 0; i < 32; i++) begin
      w = ram[i];
      d = v - w[27:18];
      if (slots < 8 && w[31] && d < 10'd16) begin
        slots++;
        for (int x = 0; x < 16; x++) begin
          col  = int'(w[17:8]) + x;
          a    = {w[7:0], d[3:0], (w[30] ? 4'(15 - x) : 4'(x))};
          data = rom[a];
          if (data != 16'h0000 && col < 640) exp_q.push_back({10'(col), data});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wren) begin
        wr_cnt++;
        wcnt[pixel_col]++;
        cap[pixel_col] = pixel_data;
        if (done_seen) note_fail("write_after_done", $sformatf("col %0d", pixel_col));
        else if (exp_q.size() == 0) note_fail("extra_write", $sformatf("col %0d data %0h", pixel_col, pixel_data));
        else begin
          e_w = exp_q.pop_front();
          check("pixel_col", pixel_col, e_w.col);
          check("pixel_data", pixel_data, e_w.data);
        end
      end
      if (fe_done) begin
        done_cnt++;
        done_seen = 1'b1;
      end
    end
  end

  task automatic run_line(input logic [9:0] v, input bit mid, output int cyc);
    build_model(v);
    wr_cnt = 0;
    done_cnt = 0;
    done_seen = 1'b0;
    foreach (wcnt[i]) wcnt[i] = 0;
    mon_en = 1'b1;
    @(negedge clk);
    start_row = 1'b1;
    next_vcount = v;
    @(negedge clk);
    start_row = 1'b0;
    cyc = 1;
    while (!fe_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mid && cyc == 50) begin
        start_row = 1'b1;
        next_vcount = 10'd216;
      end else start_row = 1'b0;
    end
    start_row = 1'b0;
    check("fe_done_within_bound", fe_done, 1);
    repeat (6) @(negedge clk);
    check("model_drained", exp_q.size(), 0);
    check("fe_done_count", done_cnt, 1);
    mon_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ra"}, ra, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_pixel_col"}, pixel_col, 0);
    check({tag, "_pixel_data"}, pixel_data, 0);
    check({tag, "_wren"}, wren, 0);
    check({tag, "_fe_done"}, fe_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s, bad;
    reset = 1'b1;
    start_row = 1'b0;
    next_vcount = '0;
    for (int i = 0; i < 32; i++) ram[i] = 32'h83200000 | ((20 * i) << 8) | i;
    for (int a = 0; a < 65536; a++) rom[a] = 16'(a) | 16'h8000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // 1: every sprite on line 200, only the first eight drawn
    run_line(10'd200, 1'b0, cyc);
    check("t1_writes", wr_cnt, 128);
    check("t1_s3_col60", cap[60], 16'h8300);
    check("t1_s3_col75", cap[75], 16'h830F);
    check("t1_no_sprite8", wcnt[160], 0);
    check("t1_done_le_200", cyc <= 200, 1);

    // 2: flipped sprite 1, row 5
    ram[1] = 32'hC3201401;
    run_line(10'd205, 1'b0, cyc);
    check("t2_col20", cap[20], 16'h815F);
    check("t2_col35", cap[35], 16'h8150);
    check("t2_writes", wr_cnt, 128);

    // 3: no sprite covers line 216
    run_line(10'd216, 1'b0, cyc);
    check("t3_writes", wr_cnt, 0);
    check("t3_scan_time_ok", (cyc >= 90 && cyc <= 110), 1);

    // 4: transparent pixels and right-edge clipping
    for (int a = 0; a < 16; a += 2) rom[a] = 16'h0000;
    ram[5] = 32'h83200000 | (630 << 8) | 5;
    run_line(10'd200, 1'b0, cyc);
    s = 0;
    for (int c = 0; c < 16; c++) s += wcnt[c];
    check("t4_sprite0_writes", s, 8);
    check("t4_col0_skipped", wcnt[0], 0);
    check("t4_col1_written", wcnt[1], 1);
    s = 0;
    for (int c = 640; c < 646; c++) s += wcnt[c];
    check("t4_offscreen_writes", s, 0);
    s = 0;
    for (int c = 630; c < 640; c++) s += wcnt[c];
    check("t4_edge_writes", s, 10);
    check("t4_writes", wr_cnt, 114);

    // 5: reset in the middle of drawing sprite 1
    @(negedge clk);
    start_row = 1'b1;
    next_vcount = 10'd200;
    @(negedge clk);
    start_row = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (fe_done) bad++;
    end
    check("t5_no_fe_done_after_abort", bad, 0);
    run_line(10'd200, 1'b1, cyc);
    check("t5_writes", wr_cnt, 114);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
